sraml_arbiter: RTL and testbench
================================

Name:
sraml_arbiter

Overview:
- Shares one downstream sram-like port between the instruction-side and data-side sram-like masters (the i/d sram→sram-like bridges).
- Output feeds the single AXI bridge.
- At most one transaction is outstanding at a time.
- Fixed priority; the grant is locked from first request until the data handshake completes.

Parameters:
DATA_PRIO, 1, 1 = data side wins a simultaneous request; 0 = inst side wins

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
inst_req  in  1  inst read request (inst side is read-only)
inst_size  in  2  inst transfer size
inst_addr  in  32  inst address
inst_addr_ok  out  1  inst address handshake
inst_data_ok  out  1  inst data handshake
inst_rdata  out  32  inst read data
data_req  in  1  data request
data_wr  in  1  1 = write
data_size  in  2  data transfer size
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data address handshake
data_data_ok  out  1  data data handshake
data_rdata  out  32  data read data
m_req  out  1  downstream request
m_wr  out  1  downstream write
m_size  out  2  downstream size
m_addr  out  32  downstream address
m_wdata  out  32  downstream write data
m_addr_ok  in  1  downstream address handshake
m_data_ok  in  1  downstream data handshake
m_rdata  in  32  downstream read data

Behaviour:
- Reset is on clk; clock is clk.
- rst forces state IDLE and owner=INST. All *_ok outputs are 0; m_req is 0 unless a master requests in IDLE.
- States:
  - IDLE: no grant.
  - LOCK: request issued, addr_ok pending.
  - WAIT: address accepted, data_ok pending.
- IDLE:
  - sel = data if data_req & (DATA_PRIO | ~inst_req); else inst if inst_req.
  - m_req = sel's req. m_wr/size/addr/wdata are muxed from sel; inst selection gives m_wr=0 and m_wdata=0.
  - m_addr_ok & ~m_data_ok → owner<=sel, go WAIT.
  - m_addr_ok & m_data_ok → owner<=sel, stay IDLE. Both handshakes are routed to sel this cycle.
  - Request without m_addr_ok → owner<=sel, go LOCK.
- LOCK:
  - Mux fixed to owner regardless of the other master's req; m_req = owner's req.
  - m_addr_ok → WAIT, or IDLE if m_data_ok in the same cycle.
  - Owner dropping req (illegal) → IDLE.
- WAIT:
  - m_req=0; the mux stays on owner.
  - m_data_ok → owner's *_data_ok=1 for exactly that cycle, go IDLE.
  - A new request is served no earlier than the next cycle (IDLE).
- Routing and latency:
  - m_addr_ok/m_data_ok are routed only to the granted/owning side; the non-owner sees 0.
  - m_rdata is broadcast to both *_rdata unregistered; zero added latency on any handshake.
- Boundary cases:
  - m_data_ok in IDLE with nothing outstanding (e.g. after rst mid-transaction) is dropped: no *_data_ok.
  - Requester stalls while the other side's transaction is in flight; no starvation guarantee beyond priority.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, LOCK=2'd1, WAIT=2'd2)
  - owner constants (OWN_INST=1'b0, OWN_DATA=1'b1)
  - size constants (SIZE_W=2'b10)
- No sub-module is needed. An optional sraml_mux2 (pure request-field mux) may be factored out.

Test Plan:
- inst_req only, addr 0xBFC00000; m_addr_ok in cycle 1, m_data_ok in cycle 3 with rdata 0x3C080001 → inst_addr_ok@1, inst_data_ok@3, inst_rdata=0x3C080001, data_* ok stay 0.
- inst_req and data_req (wr=1, addr 0x80001000, wdata 0xDEADBEEF) in the same cycle, DATA_PRIO=1 → m_addr=0x80001000, m_wr=1 first; inst is served after data_data_ok.
- inst requests, m_addr_ok held low 3 cycles, data_req rises in cycle 1 → m_addr stays the inst address (LOCK); data is served after inst completes.
- m_addr_ok & m_data_ok in the same cycle for a data read → data_addr_ok=data_data_ok=1 that cycle, state stays IDLE, a back-to-back request is accepted next cycle.
- rst asserted in WAIT, then stray m_data_ok → no *_data_ok pulse; state IDLE.
- DATA_PRIO=0 with simultaneous requests → inst is granted first.

Source files
------------

// File: rtl/sraml_arbiter_pkg.sv
// Shared encodings for the sram-like arbiter: FSM states, owner ids and size codes.
package sraml_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/sraml_arbiter.sv
// Fixed-priority arbiter sharing one sram-like port between the inst and data masters.
// One transaction outstanding at a time; the grant is held from first request to data_ok.
//
// state | meaning
// IDLE  | no grant; the winning requester drives the port directly
// LOCK  | request issued to owner, addr_ok pending
// WAIT  | address accepted, data_ok pending
module sraml_arbiter
    import sraml_arbiter_pkg::*;
#(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req_i,
    input  logic [1:0]  inst_size_i,
    input  logic [31:0] inst_addr_i,
    output logic        inst_addr_ok_o,
    output logic        inst_data_ok_o,
    output logic [31:0] inst_rdata_o,

    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,
    output logic [31:0] data_rdata_o,

    output logic        m_req_o,
    output logic        m_wr_o,
    output logic [1:0]  m_size_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_addr_ok_i,
    input  logic        m_data_ok_i,
    input  logic [31:0] m_rdata_i
);

    state_e state_q, state_d;
    state_e state_cur;
    logic   owner_q, owner_d;
    logic   sel;
    logic   side;
    logic   side_req;
    logic   present;
    logic   aok_route;
    logic   dok_route;

    // A synchronous reset still has to look like IDLE in its own cycle.
    assign state_cur = rst ? IDLE : state_q;

    always_comb begin
        sel      = (data_req_i && (DATA_PRIO || !inst_req_i)) ? OWN_DATA : OWN_INST;
        side     = (state_cur == IDLE) ? sel : owner_q;
        side_req = (side == OWN_DATA) ? data_req_i : inst_req_i;
        present  = (state_cur != WAIT) && side_req;
    end

    always_comb begin
        aok_route = present && m_addr_ok_i;
        if (state_cur == WAIT) begin
            dok_route = m_data_ok_i;
        end else begin
            dok_route = present && m_addr_ok_i && m_data_ok_i;
        end
    end

    always_comb begin
        state_d = state_cur;
        owner_d = owner_q;
        case (state_cur)
            IDLE: begin
                if (present) begin
                    owner_d = sel;
                    if (m_addr_ok_i) begin
                        state_d = m_data_ok_i ? IDLE : WAIT;
                    end else begin
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                // owner withdrawing its request abandons the transaction
                if (!present) begin
                    state_d = IDLE;
                end else if (m_addr_ok_i) begin
                    state_d = m_data_ok_i ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (m_data_ok_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_INST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        m_req_o   = present;
        m_wr_o    = 1'b0;
        m_size_o  = inst_size_i;
        m_addr_o  = inst_addr_i;
        m_wdata_o = 32'h0;
        if (side == OWN_DATA) begin
            m_wr_o    = data_wr_i;
            m_size_o  = data_size_i;
            m_addr_o  = data_addr_i;
            m_wdata_o = data_wdata_i;
        end
    end

    always_comb begin
        inst_addr_ok_o = 1'b0;
        inst_data_ok_o = 1'b0;
        data_addr_ok_o = 1'b0;
        data_data_ok_o = 1'b0;
        if (!rst) begin
            if (side == OWN_DATA) begin
                data_addr_ok_o = aok_route;
                data_data_ok_o = dok_route;
            end else begin
                inst_addr_ok_o = aok_route;
                inst_data_ok_o = dok_route;
            end
        end
    end

    assign inst_rdata_o = m_rdata_i;
    assign data_rdata_o = m_rdata_i;

endmodule

// File: tb/tb_sraml_arbiter.sv
// Bench for sraml_arbiter: directed cycle vectors plus random traffic against a transaction model.
module tb_sraml_arbiter;
    import sraml_arbiter_pkg::*;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h8000_1000;
    localparam logic [31:0] WD = 32'hDEAD_BEEF;
    localparam logic [31:0] RD = 32'h3C08_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_req = 0, d_req = 0, d_wr = 0, m_aok = 0, m_dok = 0;
    logic [1:0]  i_size = 2'b10, d_size = SIZE_W;
    logic [31:0] i_addr = IA, d_addr = DA, d_wdata = WD, m_rdata = RD;

    logic        a_iaok, a_idok, a_daok, a_ddok, a_mreq, a_mwr;
    logic [1:0]  a_msize;
    logic [31:0] a_irdata, a_drdata, a_maddr, a_mwdata;
    logic        b_iaok, b_idok, b_daok, b_ddok, b_mreq, b_mwr;
    logic [1:0]  b_msize;
    logic [31:0] b_irdata, b_drdata, b_maddr, b_mwdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sraml_arbiter #(.DATA_PRIO(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .inst_req_i(i_req), .inst_size_i(i_size), .inst_addr_i(i_addr),
        .inst_addr_ok_o(a_iaok), .inst_data_ok_o(a_idok), .inst_rdata_o(a_irdata),
        .data_req_i(d_req), .data_wr_i(d_wr), .data_size_i(d_size), .data_addr_i(d_addr),
        .data_wdata_i(d_wdata), .data_addr_ok_o(a_daok), .data_data_ok_o(a_ddok),
        .data_rdata_o(a_drdata),
        .m_req_o(a_mreq), .m_wr_o(a_mwr), .m_size_o(a_msize), .m_addr_o(a_maddr),
        .m_wdata_o(a_mwdata), .m_addr_ok_i(m_aok), .m_data_ok_i(m_dok), .m_rdata_i(m_rdata)
    );

    sraml_arbiter #(.DATA_PRIO(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .inst_req_i(i_req), .inst_size_i(i_size), .inst_addr_i(i_addr),
        .inst_addr_ok_o(b_iaok), .inst_data_ok_o(b_idok), .inst_rdata_o(b_irdata),
        .data_req_i(d_req), .data_wr_i(d_wr), .data_size_i(d_size), .data_addr_i(d_addr),
        .data_wdata_i(d_wdata), .data_addr_ok_o(b_daok), .data_data_ok_o(b_ddok),
        .data_rdata_o(b_drdata),
        .m_req_o(b_mreq), .m_wr_o(b_mwr), .m_size_o(b_msize), .m_addr_o(b_maddr),
        .m_wdata_o(b_mwdata), .m_addr_ok_i(m_aok), .m_data_ok_i(m_dok), .m_rdata_i(m_rdata)
    );

    typedef struct packed {
        logic        m_req;
        logic        m_wr;
        logic [1:0]  m_size;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic        iaok;
        logic        idok;
        logic        daok;
        logic        ddok;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } obs_t;

    typedef struct {
        string       name;
        bit          use_b;
        bit          rst, i_req, d_req, d_wr, aok, dok;
        logic        e_req, e_wr;
        logic [31:0] e_addr;
        logic [3:0]  e_ok;
    } vec_t;

    function automatic vec_t mkv(input string n, input bit ub, input bit r, input bit ir,
                                 input bit dr, input bit w, input bit a, input bit dk,
                                 input logic er, input logic ew, input logic [31:0] ea,
                                 input logic [3:0] eo);
        vec_t v;
        v.name = n; v.use_b = ub; v.rst = r; v.i_req = ir; v.d_req = dr; v.d_wr = w;
        v.aok = a; v.dok = dk; v.e_req = er; v.e_wr = ew; v.e_addr = ea; v.e_ok = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [37:0] got;
        @(negedge clk);
        rst = v.rst; i_req = v.i_req; d_req = v.d_req; d_wr = v.d_wr;
        m_aok = v.aok; m_dok = v.dok;
        i_addr = IA; d_addr = DA; d_wdata = WD; m_rdata = RD;
        i_size = 2'b10; d_size = SIZE_W;
        #1;
        if (v.use_b) got = {b_mreq, b_mwr, b_maddr, b_iaok, b_idok, b_daok, b_ddok};
        else         got = {a_mreq, a_mwr, a_maddr, a_iaok, a_idok, a_daok, a_ddok};
        check(v.name, 136'(got), 136'({v.e_req, v.e_wr, v.e_addr, v.e_ok}));
    endtask

    function automatic obs_t observe(input bit which);
        obs_t o;
        if (which) o = '{b_mreq, b_mwr, b_msize, b_maddr, b_mwdata,
                         b_iaok, b_idok, b_daok, b_ddok, b_irdata, b_drdata};
        else       o = '{a_mreq, a_mwr, a_msize, a_maddr, a_mwdata,
                         a_iaok, a_idok, a_daok, a_ddok, a_irdata, a_drdata};
        return o;
    endfunction

    // Transaction view: own = -1 when nothing is granted, else 0 (inst) / 1 (data);
    // acc marks that the granted transaction is only waiting for its data.
    function automatic obs_t model(input bit prio, input int own, input bit acc,
                                   output int own_n, output bit acc_n);
        obs_t e;
        int   side;
        bit   idle, waiting, active, hs_a, hs_d;
        idle    = rst || (own < 0);
        waiting = !idle && acc;
        if (idle) side = (d_req && (prio || !i_req)) ? 1 : 0;
        else      side = own;
        active  = !waiting && ((side == 1) ? d_req : i_req);
        hs_a    = !rst && active && m_aok;
        hs_d    = !rst && (waiting ? m_dok : (active && m_aok && m_dok));
        e.m_req   = active;
        e.m_wr    = (side == 1) ? d_wr : 1'b0;
        e.m_size  = (side == 1) ? d_size : i_size;
        e.m_addr  = (side == 1) ? d_addr : i_addr;
        e.m_wdata = (side == 1) ? d_wdata : 32'h0;
        e.iaok    = (side == 0) && hs_a;
        e.idok    = (side == 0) && hs_d;
        e.daok    = (side == 1) && hs_a;
        e.ddok    = (side == 1) && hs_d;
        e.irdata  = m_rdata;
        e.drdata  = m_rdata;
        if (rst) begin
            own_n = -1; acc_n = 0;
        end else if (waiting) begin
            own_n = m_dok ? -1 : own; acc_n = !m_dok;
        end else if (!active) begin
            own_n = -1; acc_n = 0;
        end else if (m_aok) begin
            own_n = m_dok ? -1 : side; acc_n = !m_dok;
        end else begin
            own_n = side; acc_n = 0;
        end
        return e;
    endfunction

    vec_t tbl[$];

    initial begin
        int   own_a, own_b, na, nb;
        bit   acc_a, acc_b, nacc_a, nacc_b;
        obs_t ea, eb;

        //                name        ub r  i  d  w  a  dk  req wr  addr  {ia,id,da,dd}
        tbl.push_back(mkv("rst",      0, 1, 0, 0, 0, 0, 0,  0,  0,  IA, 4'b0000));
        tbl.push_back(mkv("s1_req",   0, 0, 1, 0, 0, 0, 0,  1,  0,  IA, 4'b0000));
        tbl.push_back(mkv("s1_aok",   0, 0, 1, 0, 0, 1, 0,  1,  0,  IA, 4'b1000));
        tbl.push_back(mkv("s1_wait",  0, 0, 0, 0, 0, 0, 0,  0,  0,  IA, 4'b0000));
        tbl.push_back(mkv("s1_dok",   0, 0, 0, 0, 0, 0, 1,  0,  0,  IA, 4'b0100));
        tbl.push_back(mkv("s2_both",  0, 0, 1, 1, 1, 1, 0,  1,  1,  DA, 4'b0010));
        tbl.push_back(mkv("s2_ddok",  0, 0, 1, 0, 1, 0, 1,  0,  1,  DA, 4'b0001));
        tbl.push_back(mkv("s2_inst",  0, 0, 1, 0, 0, 1, 0,  1,  0,  IA, 4'b1000));
        tbl.push_back(mkv("s2_idok",  0, 0, 0, 0, 0, 0, 1,  0,  0,  IA, 4'b0100));
        tbl.push_back(mkv("s4_same",  0, 0, 0, 1, 0, 1, 1,  1,  0,  DA, 4'b0011));
        tbl.push_back(mkv("s4_b2b",   0, 0, 0, 1, 0, 1, 0,  1,  0,  DA, 4'b0010));
        tbl.push_back(mkv("s4_dok",   0, 0, 0, 0, 0, 0, 1,  0,  0,  DA, 4'b0001));
        tbl.push_back(mkv("s5_aok",   0, 0, 1, 0, 0, 1, 0,  1,  0,  IA, 4'b1000));
        tbl.push_back(mkv("s5_rst",   0, 1, 0, 0, 0, 0, 1,  0,  0,  IA, 4'b0000));
        tbl.push_back(mkv("s5_stray", 0, 0, 0, 0, 0, 0, 1,  0,  0,  IA, 4'b0000));
        tbl.push_back(mkv("s5_idle",  0, 0, 1, 0, 0, 0, 0,  1,  0,  IA, 4'b0000));
        tbl.push_back(mkv("s5_drop",  0, 0, 0, 1, 0, 1, 0,  0,  0,  IA, 4'b0000));
        tbl.push_back(mkv("s5_after", 0, 0, 0, 1, 0, 0, 0,  1,  0,  DA, 4'b0000));
        tbl.push_back(mkv("s5_fin",   0, 0, 0, 1, 0, 1, 1,  1,  0,  DA, 4'b0011));

        foreach (tbl[k]) apply(tbl[k]);

        // inst locked while m_addr_ok is withheld; data arrives mid-lock and must wait
        apply(mkv("s3_rst",   0, 1, 0, 0, 0, 0, 0,  0,  0,  IA, 4'b0000));
        apply(mkv("s3_lock0", 0, 0, 1, 0, 0, 0, 0,  1,  0,  IA, 4'b0000));
        apply(mkv("s3_lock1", 0, 0, 1, 1, 1, 0, 0,  1,  0,  IA, 4'b0000));
        apply(mkv("s3_lock2", 0, 0, 1, 1, 1, 0, 0,  1,  0,  IA, 4'b0000));
        apply(mkv("s3_aok",   0, 0, 1, 1, 1, 1, 0,  1,  0,  IA, 4'b1000));
        apply(mkv("s3_idok",  0, 0, 0, 1, 1, 0, 1,  0,  0,  IA, 4'b0100));
        apply(mkv("s3_data",  0, 0, 0, 1, 1, 1, 0,  1,  1,  DA, 4'b0010));
        apply(mkv("s3_ddok",  0, 0, 0, 0, 0, 0, 1,  0,  0,  DA, 4'b0001));

        // inst-priority instance with simultaneous requests
        apply(mkv("p0_rst",   1, 1, 0, 0, 0, 0, 0,  0,  0,  IA, 4'b0000));
        apply(mkv("p0_both",  1, 0, 1, 1, 1, 1, 0,  1,  0,  IA, 4'b1000));
        apply(mkv("p0_idok",  1, 0, 0, 1, 1, 0, 1,  0,  0,  IA, 4'b0100));
        apply(mkv("p0_data",  1, 0, 0, 1, 1, 1, 0,  1,  1,  DA, 4'b0010));
        apply(mkv("p0_ddok",  1, 0, 0, 0, 0, 0, 1,  0,  0,  DA, 4'b0001));

        own_a = -1; own_b = -1; acc_a = 0; acc_b = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst     = (c == 0) || ($urandom_range(0, 63) == 0);
            i_req   = ($urandom_range(0, 9) < 6);
            d_req   = ($urandom_range(0, 9) < 6);
            d_wr    = $urandom_range(0, 1) == 1;
            i_size  = 2'($urandom_range(0, 3));
            d_size  = 2'($urandom_range(0, 3));
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            m_rdata = $urandom;
            m_aok   = ($urandom_range(0, 9) < 5);
            m_dok   = ($urandom_range(0, 9) < 4);
            #1;
            ea = model(1'b1, own_a, acc_a, na, nacc_a);
            eb = model(1'b0, own_b, acc_b, nb, nacc_b);
            check("rand_prio1", observe(1'b0), ea);
            check("rand_prio0", observe(1'b1), eb);
            own_a = na; acc_a = nacc_a;
            own_b = nb; acc_b = nacc_b;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
